// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: bundle of request, FPU and response signals around fpu_arbiter.
//   slave  modport: the arbiter's view (takes requests and the FPU reply, drives
//                   grants, FPU operands/operation, response and busy).
//   master modport: the environment's view (requesters plus the FPU).
// Signals:
//   r0_/r1_valid, r0_/r1_op1, r0_/r1_op2, r0_/r1_operation  requester inputs
//   r0_/r1_ready                                            accept strobes
//   fpu_operand_1/2, fpu_operation                          to the FPU
//   fpu_result, fpu_ready                                   from the FPU
//   resp_valid, resp_id, resp_result, resp_error            tagged response
//   busy                                                    job in flight
interface fpu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             r0_valid;
  logic             r1_valid;
  logic             r0_ready;
  logic             r1_ready;
  logic [WIDTH-1:0] r0_op1;
  logic [WIDTH-1:0] r0_op2;
  logic [WIDTH-1:0] r1_op1;
  logic [WIDTH-1:0] r1_op2;
  logic [1:0]       r0_operation;
  logic [1:0]       r1_operation;
  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  logic             resp_valid;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_error;
  logic             busy;

  modport slave (
    input  r0_valid, r1_valid, r0_op1, r0_op2, r1_op1, r1_op2,
    input  r0_operation, r1_operation, fpu_result, fpu_ready,
    output r0_ready, r1_ready, fpu_operand_1, fpu_operand_2, fpu_operation,
    output resp_valid, resp_id, resp_result, resp_error, busy
  );

  modport master (
    output r0_valid, r1_valid, r0_op1, r0_op2, r1_op1, r1_op2,
    output r0_operation, r1_operation, fpu_result, fpu_ready,
    input  r0_ready, r1_ready, fpu_operand_1, fpu_operand_2, fpu_operation,
    input  resp_valid, resp_id, resp_result, resp_error, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fixed-point unit between two requesters.
// One job at a time, round-robin when both request. The accepted job's operands
// and operation are latched and held on the FPU until fpu_ready, then the result
// is returned as a one-cycle tagged strobe. Between jobs the FPU is parked on
// FPU_ADD with zero operands so its multi-cycle stage counters restart cleanly.
// Operation encodings: ADD=0, SUB=1, MUL=2, SQRT=3.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    fpu_arbiter_if.slave (requests, FPU link, response, busy)
// Build option: define FPU_ARB_TIMEOUT_EN to abort a job after TIMEOUT ISSUE
// cycles without fpu_ready (response with resp_error=1, resp_result=0).
// Without it ISSUE waits indefinitely and resp_error is constant 0.
module fpu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          reset,
  fpu_arbiter_if.slave bus
);
  localparam logic [1:0] FPU_ADD = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             prio_r1;   // 1: r1 wins the next tie
  logic             grant_r0;
  logic             grant_r1;
  logic             id_q;
  logic             busy_q;
  logic [1:0]       operation_q;
  logic [WIDTH-1:0] operand_1_q;
  logic [WIDTH-1:0] operand_2_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_result_q;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             resp_error_q;
  logic             limit_hit;

  // The increment in this cycle would bring the counter to TIMEOUT.
  assign limit_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  // TIMEOUT only matters when the timeout build is selected.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Grants are only made in IDLE and never while reset is held.
  always_comb begin
    grant_r0 = 1'b0;
    grant_r1 = 1'b0;
    if (reset && state == IDLE) begin
      if (bus.r0_valid && !(bus.r1_valid && prio_r1)) grant_r0 = 1'b1;
      else if (bus.r1_valid)                           grant_r1 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      prio_r1       <= 1'b0;
      id_q          <= 1'b0;
      busy_q        <= 1'b0;
      operation_q   <= FPU_ADD;
      operand_1_q   <= '0;
      operand_2_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      resp_error_q  <= 1'b0;
`endif
    end else begin
      // Response fields read as zero outside the single strobe cycle.
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      resp_error_q  <= 1'b0;
`endif
      case (state)
        // IDLE -> ISSUE: latch the winner's job and move the tie pointer.
        IDLE: begin
          if (grant_r0 || grant_r1) begin
            state       <= ISSUE;
            busy_q      <= 1'b1;
            id_q        <= grant_r1;
            prio_r1     <= grant_r0;
            operation_q <= grant_r1 ? bus.r1_operation : bus.r0_operation;
            operand_1_q <= grant_r1 ? bus.r1_op1 : bus.r0_op1;
            operand_2_q <= grant_r1 ? bus.r1_op2 : bus.r0_op2;
`ifdef FPU_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        // ISSUE -> DONE: capture the result and park the FPU on ADD/0.
        ISSUE: begin
          if (bus.fpu_ready) begin
            state         <= DONE;
            resp_valid_q  <= 1'b1;
            resp_id_q     <= id_q;
            resp_result_q <= bus.fpu_result;
            operation_q   <= FPU_ADD;
            operand_1_q   <= '0;
            operand_2_q   <= '0;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (limit_hit) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_id_q    <= id_q;
              resp_error_q <= 1'b1;
              operation_q  <= FPU_ADD;
              operand_1_q  <= '0;
              operand_2_q  <= '0;
            end
          end
`endif
        end
        // DONE -> IDLE: response strobe is on the bus this cycle.
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_ready      = grant_r0;
  assign bus.r1_ready      = grant_r1;
  assign bus.fpu_operation = operation_q;
  assign bus.fpu_operand_1 = operand_1_q;
  assign bus.fpu_operand_2 = operand_2_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_result   = resp_result_q;
  assign bus.busy          = busy_q;
`ifdef FPU_ARB_TIMEOUT_EN
  assign bus.resp_error    = resp_error_q;
`else
  assign bus.resp_error    = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed bench for fpu_arbiter with a behavioural fixed-point
// FPU (FBITS=10): ADD/SUB ready immediately, MUL ready in its 6th cycle, SQRT in
// its 24th; the FPU stage counter restarts whenever it sees ADD or SUB.
module tb_fpu_arbiter;
  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, SQRT = 2'd3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpu_arbiter_if #(.WIDTH(32)) bus();
  fpu_arbiter #(.WIDTH(32), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  bit stub_hang = 1'b0;
  bit force_rdy = 1'b0;

  logic [7:0]  fpu_cnt;
  logic        model_rdy;
  logic [31:0] model_res;
  logic [63:0] prod;

  function automatic logic [31:0] isqrt(input logic [63:0] x);
    logic [63:0] r, t;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= x) r = t;
    end
    return r[31:0];
  endfunction

  always @(posedge clk)
    fpu_cnt <= (bus.fpu_operation == ADD || bus.fpu_operation == SUB) ? 8'd0 :
               (fpu_cnt == 8'hFF ? fpu_cnt : fpu_cnt + 8'd1);

  always_comb begin
    model_rdy = 1'b1;
    model_res = '0;
    prod = {{32{bus.fpu_operand_1[31]}}, bus.fpu_operand_1} *
           {{32{bus.fpu_operand_2[31]}}, bus.fpu_operand_2};
    case (bus.fpu_operation)
      ADD:  model_res = bus.fpu_operand_1 + bus.fpu_operand_2;
      SUB:  model_res = bus.fpu_operand_1 - bus.fpu_operand_2;
      MUL:  begin model_res = prod[41:10]; model_rdy = (fpu_cnt >= 8'd5); end
      default: begin model_res = isqrt({22'd0, bus.fpu_operand_1, 10'd0}); model_rdy = (fpu_cnt >= 8'd23); end
    endcase
  end

  assign bus.fpu_result = model_res;
  assign bus.fpu_ready  = force_rdy | (model_rdy & ~stub_hang);

  always @(negedge clk) if (bus.resp_valid === 1'b1) resp_cnt <= resp_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one job, returns at the response cycle (or after max_cyc cycles).
  task automatic run_job(input bit who, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int max_cyc, output bit acc,
                         output int lat, output bit got, output logic [31:0] res,
                         output logic rid, output logic rerr, output bit stable);
    got = 1'b0; stable = 1'b1; res = '0; rid = 1'b0; rerr = 1'b0;
    if (who) begin bus.r1_operation = op; bus.r1_op1 = a; bus.r1_op2 = b; bus.r1_valid = 1'b1; end
    else     begin bus.r0_operation = op; bus.r0_op1 = a; bus.r0_op2 = b; bus.r0_valid = 1'b1; end
    #1;
    acc = who ? (bus.r1_ready === 1'b1 && bus.r0_ready === 1'b0)
              : (bus.r0_ready === 1'b1 && bus.r1_ready === 1'b0);
    tick();
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    lat = 1;
    while (!got && lat <= max_cyc) begin
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1; res = bus.resp_result; rid = bus.resp_id; rerr = bus.resp_error;
      end else begin
        if (bus.fpu_operation !== op || bus.fpu_operand_1 !== a || bus.fpu_operand_2 !== b) stable = 1'b0;
        tick();
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    bus.r0_valid = 1'b1; bus.r0_operation = MUL;
    #1;
    checks++; if (bus.r0_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_ready: got %b want 0", bus.r0_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.fpu_operation !== ADD) begin errors++; $display("FAIL reset_fpu_operation: got %0d want 0", bus.fpu_operation); end
    checks++; if (bus.fpu_operand_1 !== 32'h0 || bus.fpu_operand_2 !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h %h want 0 0", bus.fpu_operand_1, bus.fpu_operand_2); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_id !== 1'b0 || bus.resp_result !== 32'h0 || bus.resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp: got v=%b id=%b r=%h e=%b want all 0", bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_error); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept: busy got %b want 0", bus.busy); end
    bus.r0_valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    bus.r0_operation = ADD; bus.r0_op1 = 32'h0000_0C00; bus.r0_op2 = 32'h0000_0400; bus.r0_valid = 1'b1;
    #1;
    checks++; if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin errors++; $display("FAIL add_accept: got r0=%b r1=%b want 1 0", bus.r0_ready, bus.r1_ready); end
    tick();
    bus.r0_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.fpu_operand_1 !== 32'hC00 || bus.fpu_operand_2 !== 32'h400) begin errors++; $display("FAIL add_issue: got busy=%b op1=%h op2=%h want 1 c00 400", bus.busy, bus.fpu_operand_1, bus.fpu_operand_2); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL add_early_resp: got %b want 0", bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_result !== 32'h0000_1000) begin errors++; $display("FAIL add_resp: got v=%b id=%b r=%h want 1 0 00001000", bus.resp_valid, bus.resp_id, bus.resp_result); end
    checks++; if (bus.fpu_operation !== ADD || bus.fpu_operand_1 !== 32'h0 || bus.busy !== 1'b1) begin errors++; $display("FAIL add_done_park: got op=%0d op1=%h busy=%b want 0 0 1", bus.fpu_operation, bus.fpu_operand_1, bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_result !== 32'h0) begin errors++; $display("FAIL add_idle: got busy=%b v=%b r=%h want 0 0 0", bus.busy, bus.resp_valid, bus.resp_result); end
  endtask

  task automatic test_mul();
    bit acc, got, stable; int lat; logic [31:0] res; logic rid, rerr;
    int c0;
    c0 = resp_cnt;
    run_job(1'b1, MUL, 32'h800, 32'h600, 60, acc, lat, got, res, rid, rerr, stable);
    checks++; if (!acc) begin errors++; $display("FAIL mul1_accept: got 0 want 1"); end
    checks++; if (!got || lat != 7) begin errors++; $display("FAIL mul1_latency: got resp=%b lat=%0d want 1 7", got, lat); end
    checks++; if (!stable) begin errors++; $display("FAIL mul1_op_stable: got unstable want stable MUL"); end
    checks++; if (res !== 32'h0000_0C00 || rid !== 1'b1 || rerr !== 1'b0) begin errors++; $display("FAIL mul1_resp: got r=%h id=%b e=%b want 00000c00 1 0", res, rid, rerr); end
    tick();
    run_job(1'b1, MUL, 32'h400, 32'h400, 60, acc, lat, got, res, rid, rerr, stable);
    checks++; if (!acc || !got || !stable) begin errors++; $display("FAIL mul2_flow: got acc=%b resp=%b stable=%b want 1 1 1", acc, got, stable); end
    checks++; if (res !== 32'h0000_0400 || rid !== 1'b1) begin errors++; $display("FAIL mul2_resp: got r=%h id=%b want 00000400 1", res, rid); end
    tick();
    checks++; if (resp_cnt - c0 != 2) begin errors++; $display("FAIL mul_resp_count: got %0d want 2", resp_cnt - c0); end
  endtask

  task automatic test_sqrt();
    bit acc, got, stable; int lat; logic [31:0] res; logic rid, rerr;
    int c0;
    c0 = resp_cnt;
    run_job(1'b0, SQRT, 32'h1000, 32'h0, 60, acc, lat, got, res, rid, rerr, stable);
    checks++; if (!acc || !got || !stable || lat != 25) begin errors++; $display("FAIL sqrt1_flow: got acc=%b resp=%b stable=%b lat=%0d want 1 1 1 25", acc, got, stable, lat); end
    checks++; if (res !== 32'h0000_0800 || rid !== 1'b0) begin errors++; $display("FAIL sqrt1_resp: got r=%h id=%b want 00000800 0", res, rid); end
    tick();
    run_job(1'b1, SQRT, 32'h2400, 32'h0, 60, acc, lat, got, res, rid, rerr, stable);
    checks++; if (!acc || !got || !stable) begin errors++; $display("FAIL sqrt2_flow: got acc=%b resp=%b stable=%b want 1 1 1", acc, got, stable); end
    checks++; if (res !== 32'h0000_0C00 || rid !== 1'b1) begin errors++; $display("FAIL sqrt2_resp: got r=%h id=%b want 00000c00 1", res, rid); end
    repeat (6) tick();
    checks++; if (resp_cnt - c0 != 2 || bus.busy !== 1'b0) begin errors++; $display("FAIL sqrt_resp_count: got %0d busy=%b want 2 0", resp_cnt - c0, bus.busy); end
  endtask

  task automatic test_contention();
    int gwho[4], gcyc[4], ng, rres[4], rids[4], nr;
    bit both;
    logic [31:0] exp_res[4];
    exp_res[0] = 32'h300; exp_res[1] = 32'h1010; exp_res[2] = 32'h900; exp_res[3] = 32'h1010;
    ng = 0; nr = 0; both = 1'b0;
    bus.r0_operation = ADD; bus.r0_op1 = 32'h100;  bus.r0_op2 = 32'h200; bus.r0_valid = 1'b1;
    bus.r1_operation = ADD; bus.r1_op1 = 32'h1000; bus.r1_op2 = 32'h10;  bus.r1_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) bus.r0_op1 = 32'h700;
      #1;
      if (bus.r0_ready === 1'b1 && bus.r1_ready === 1'b1) both = 1'b1;
      if (bus.r0_ready === 1'b1 || bus.r1_ready === 1'b1) begin
        if (ng < 4) begin gwho[ng] = (bus.r1_ready === 1'b1) ? 1 : 0; gcyc[ng] = c; end
        ng++;
      end
      if (bus.resp_valid === 1'b1) begin
        if (nr < 4) begin rres[nr] = int'(bus.resp_result); rids[nr] = int'(bus.resp_id); end
        nr++;
      end
      tick();
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    checks++; if (ng != 4 || both) begin errors++; $display("FAIL cont_grant_count: got %0d both=%b want 4 0", ng, both); end
    checks++; if (nr != 4) begin errors++; $display("FAIL cont_resp_count: got %0d want 4", nr); end
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        checks++; if (gwho[i] != i % 2 || gcyc[i] != 3 * i) begin errors++; $display("FAIL cont_grant_%0d: got who=%0d cyc=%0d want %0d %0d", i, gwho[i], gcyc[i], i % 2, 3 * i); end
      end
      if (i < nr) begin
        checks++; if (rres[i] != int'(exp_res[i]) || rids[i] != i % 2) begin errors++; $display("FAIL cont_resp_%0d: got r=%h id=%0d want %h %0d", i, rres[i], rids[i], exp_res[i], i % 2); end
      end
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_job();
    int c0;
    bus.r0_operation = SQRT; bus.r0_op1 = 32'h1000; bus.r0_op2 = 32'h0; bus.r0_valid = 1'b1;
    #1;
    tick();
    bus.r0_valid = 1'b0;
    repeat (4) tick();
    checks++; if (bus.busy !== 1'b1 || bus.fpu_operation !== SQRT) begin errors++; $display("FAIL rst_pre_issue: got busy=%b op=%0d want 1 3", bus.busy, bus.fpu_operation); end
    c0 = resp_cnt;
    reset = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.fpu_operation !== ADD || bus.fpu_operand_1 !== 32'h0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_job: got busy=%b op=%0d op1=%h v=%b want 0 0 0 0", bus.busy, bus.fpu_operation, bus.fpu_operand_1, bus.resp_valid); end
    reset = 1'b1;
    repeat (30) tick();
    checks++; if (resp_cnt != c0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got %0d responses busy=%b want 0 0", resp_cnt - c0, bus.busy); end
    bus.r0_operation = SUB; bus.r0_op1 = 32'h800; bus.r0_op2 = 32'hC00; bus.r0_valid = 1'b1;
    bus.r1_operation = ADD; bus.r1_op1 = 32'h1;   bus.r1_op2 = 32'h1;   bus.r1_valid = 1'b1;
    #1;
    checks++; if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin errors++; $display("FAIL rst_pointer: got r0=%b r1=%b want 1 0", bus.r0_ready, bus.r1_ready); end
    tick();
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    tick();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'hFFFF_FC00 || bus.resp_id !== 1'b0) begin errors++; $display("FAIL rst_sub_resp: got v=%b r=%h id=%b want 1 fffffc00 0", bus.resp_valid, bus.resp_result, bus.resp_id); end
    tick();
  endtask

  task automatic test_timeout();
`ifdef FPU_ARB_TIMEOUT_EN
    bit got; int lat;
    stub_hang = 1'b1;
    bus.r0_operation = MUL; bus.r0_op1 = 32'h800; bus.r0_op2 = 32'h800; bus.r0_valid = 1'b1;
    #1;
    tick();
    bus.r0_valid = 1'b0;
    got = 1'b0; lat = 1;
    while (!got && lat <= 40) begin
      if (bus.resp_valid === 1'b1) got = 1'b1; else begin tick(); lat++; end
    end
    checks++; if (!got || lat != TO + 1) begin errors++; $display("FAIL to_latency: got resp=%b lat=%0d want 1 %0d", got, lat, TO + 1); end
    checks++; if (bus.resp_error !== 1'b1 || bus.resp_result !== 32'h0 || bus.resp_id !== 1'b0) begin errors++; $display("FAIL to_resp: got e=%b r=%h id=%b want 1 0 0", bus.resp_error, bus.resp_result, bus.resp_id); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.resp_error !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b e=%b want 0 0", bus.busy, bus.resp_error); end
    bus.r0_valid = 1'b1;
    #1;
    tick();
    bus.r0_valid = 1'b0;
    got = 1'b0; lat = 1;
    while (!got && lat <= 40) begin
      if (lat == TO) force_rdy = 1'b1;
      if (bus.resp_valid === 1'b1) got = 1'b1; else begin tick(); lat++; end
    end
    force_rdy = 1'b0;
    checks++; if (!got || lat != TO + 1 || bus.resp_error !== 1'b0 || bus.resp_result !== 32'h1000) begin errors++; $display("FAIL to_ready_wins: got resp=%b lat=%0d e=%b r=%h want 1 %0d 0 00001000", got, lat, bus.resp_error, bus.resp_result, TO + 1); end
    stub_hang = 1'b0;
    tick();
`else
    bit bad;
    stub_hang = 1'b1;
    bus.r0_operation = MUL; bus.r0_op1 = 32'h800; bus.r0_op2 = 32'h800; bus.r0_valid = 1'b1;
    #1;
    checks++; if (bus.r0_ready !== 1'b1) begin errors++; $display("FAIL hang_accept: got %b want 1", bus.r0_ready); end
    tick();
    bus.r0_valid = 1'b0;
    bad = 1'b0;
    repeat (200) begin
      if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_error !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL hang_busy: got early exit want busy held 200 cycles"); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    stub_hang = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hang_recover: got busy=%b want 0", bus.busy); end
`endif
  endtask

  initial begin
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    bus.r0_op1 = '0; bus.r0_op2 = '0; bus.r1_op1 = '0; bus.r1_op2 = '0;
    bus.r0_operation = ADD; bus.r1_operation = ADD;
    test_reset();
    test_add();
    test_mul();
    test_sqrt();
    test_contention();
    test_reset_mid_job();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t want finish", $time);
    $fatal(1);
  end
endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one fixed-point unit (add/sub/mul/sqrt, `operation` encodings from `Defines.vh`) between two requesters, e.g. the execute stage and a vector/helper sequencer. Accepts one request at a time with round-robin priority, latches its operands, holds the FPU operation stable until the FPU raises `ready`, and returns the result on a shared, tagged response port. Between jobs it parks the FPU on `FPU_ADD` so the FPU's multi-cycle stage counters restart cleanly for the next job.

## Interface
- `WIDTH`, 32: operand and result width.
- `TIMEOUT`, 64: maximum cycles to wait for `fpu_ready`. Used only with the timeout feature.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-low reset. Sampled on `clk`.
- `r0_valid`, `r1_valid`  in  1 each: request pending.
- `r0_ready`, `r1_ready`  out  1 each: request accepted this cycle.
- `r0_op1`, `r0_op2`, `r1_op1`, `r1_op2`  in  WIDTH each: operands.
- `r0_operation`, `r1_operation`  in  2 each: `FPU_ADD`, `FPU_SUB`, `FPU_MUL` or `FPU_SQRT`.
- `fpu_operand_1`, `fpu_operand_2`  out  WIDTH each: to FPU.
- `fpu_operation`  out  2: to FPU.
- `fpu_result`  in  WIDTH: from FPU.
- `fpu_ready`  in  1: from FPU.
- `resp_valid`  out  1: one-cycle response strobe. No backpressure.
- `resp_id`  out  1: requester that owns the response.
- `resp_result`  out  WIDTH: result.
- `resp_error`  out  1: job aborted by timeout.
- `busy`  out  1: high in ISSUE and DONE.

## Operation
- State machine states: IDLE, ISSUE, DONE. Encoding is free.
- **IDLE**
  - Drives `fpu_operation=FPU_ADD` and both FPU operands 0.
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not granted last. The pointer resets to favour r0.
  - On grant: `rN_ready=1` combinationally for one cycle; latch operands, operation and id; advance the pointer; go to ISSUE.
- **ISSUE**
  - Drives the latched operands and operation, unchanged every cycle.
  - In the first cycle `fpu_ready` is 1, capture `fpu_result` and go to DONE.
- **DONE**
  - `resp_valid=1` with captured id and result.
  - Drives `fpu_operation=FPU_ADD` with zero operands, which flushes the FPU stage counters.
  - Next state: IDLE. No grants are made in DONE.
- `rN_ready` is never asserted outside IDLE. Requesters hold their inputs stable while valid and not ready.
- Operands are sampled only at accept. Later changes on `rN_op*` have no effect on the in-flight job.
- `fpu_ready` seen in IDLE or DONE is ignored. This covers FPU `ready` lingering high after sqrt.
- Reset low:
  - State IDLE, pointer favours r0.
  - All outputs 0 except `fpu_operation=FPU_ADD`.
  - Latched operands, result and timeout counter cleared.
  - Reset mid-job discards the job; no response is issued.

## Timing
- Accept in cycle T. ISSUE begins at T+1.
- ADD/SUB: `fpu_ready` is high in T+1, so `resp_valid` at T+2, IDLE at T+3. Next accept is possible at T+3.
- MUL/SQRT: `resp_valid` comes one cycle after the first ISSUE cycle with `fpu_ready`. Latency is set by the FPU: MUL about 6 ISSUE cycles, SQRT about 24 at WIDTH=32, FBITS=10.
- Minimum spacing between accepts is 3 cycles.
- `resp_*` outputs are registered and valid only while `resp_valid`. Otherwise `resp_id`, `resp_result` and `resp_error` are 0.

## Configuration
- `FPU_ARB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` clears on entering ISSUE and increments each ISSUE cycle without `fpu_ready`.
  - When it reaches TIMEOUT: go to DONE with `resp_error=1` and `resp_result=0`.
  - `fpu_ready` in the same cycle as the limit wins: normal response, `resp_error=0`.
- Not defined:
  - No counter.
  - ISSUE waits indefinitely.
  - `resp_error` is tied 0.

## Test plan
- ADD: r0 sends 0x00000C00 + 0x00000400 -> `r0_ready` at T, `resp_valid` at T+2 with `resp_id=0`, `resp_result=0x00001000`, `busy` low at T+3.
- MUL: r1 sends 0x00000800 × 0x00000600 with the real FPU (FBITS=10) -> `fpu_operation=FPU_MUL` held stable through ISSUE, single response 0x00000C00 with id 1. A back-to-back second MUL 0x00000400 × 0x00000400 -> 0x00000400.
- SQRT then SQRT: 0x00001000 -> 0x00000800, then 0x00002400 -> 0x00000C00. Exactly two `resp_valid` pulses; the lingering FPU `ready` does not produce a spurious response.
- Contention: r0 and r1 valid continuously with ADDs -> grants alternate r0,r1,r0,r1, each accept 3 cycles apart. Changing `r0_op1` after accept does not alter that job's result.
- Reset mid-job: drop `reset` during a SQRT ISSUE -> next cycle IDLE, `busy=0`, `fpu_operation=FPU_ADD`, no `resp_valid`. A fresh SUB 0x00000800 - 0x00000C00 after release -> 0xFFFFFC00.
- With `FPU_ARB_TIMEOUT_EN`, TIMEOUT=8, stub `fpu_ready=0`: `resp_valid` with `resp_error=1`, `resp_result=0` exactly 8 ISSUE cycles after accept. Without the macro, `busy` stays high for 200 cycles.
